// File: rtl/hazard_fwd_unit_if.sv
// hazard_fwd_unit_if
//   Bundles the ID-stage operand fields, the MEM branch decision and the
//   hazard/forwarding results exchanged with hazard_fwd_unit.
//   master : pipeline side (drives ID fields and mem_branch_taken)
//   slave  : hazard unit side (drives stall, flush, fwd_a/b, counters)
interface hazard_fwd_unit_if #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16,
    parameter int SW     = $clog2(DEPTH + 1)
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic              id_regwrite;
    logic [REG_AW-1:0] id_rd;
    logic              id_memread;
    logic              mem_branch_taken;
    logic              stall;
    logic              flush;
    logic [SW-1:0]     fwd_a;
    logic [SW-1:0]     fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_regwrite, id_rd,
               id_memread, mem_branch_taken,
        input  stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_regwrite, id_rd,
               id_memread, mem_branch_taken,
        output stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard control for the five-stage pipeline. A DEPTH-entry shift register
//   tracks in-flight destinations (entry 1 = EX, 2 = MEM, 3 = WB). From it the
//   unit derives the load-use stall, the branch flush and registered EX
//   forwarding selects, plus saturating stall/flush event counters.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - hazard_fwd_unit_if.slave: ID operand fields, mem_branch_taken in;
//            stall, flush (combinational), fwd_a, fwd_b (registered),
//            stall_cnt, flush_cnt out
module hazard_fwd_unit #(
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 3,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16,
    parameter int SW          = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    hazard_fwd_unit_if.slave       bus
);

    typedef struct packed {
        logic              v;
        logic              wr;
        logic              ld;
        logic [REG_AW-1:0] rd;
    } entry_t;

    entry_t           sb [1:DEPTH];
    logic [DEPTH:1]   match_rs;
    logic [DEPTH:1]   match_rt;
    logic [SW-1:0]    sel_a;
    logic [SW-1:0]    sel_b;
    logic             hazard;
    logic             stall;
    logic             flush;
    logic             issue;
    logic [SW-1:0]    fwd_a_q;
    logic [SW-1:0]    fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Producer match per entry; register 0 is never a producer.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        match_rs = '0;
        match_rt = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (sb[k].v && sb[k].wr && (sb[k].rd != '0)) begin
                match_rs[k] = (sb[k].rd == bus.id_rs);
                match_rt[k] = bus.id_uses_rt && (sb[k].rd == bus.id_rt);
            end
        end
    end

    // Nearest producer wins: scan from the oldest entry down so the lowest
    // matching index is the last assignment.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (match_rs[k]) sel_a = SW'(k);
            if (match_rt[k]) sel_b = SW'(k);
        end
    end

    // A load only blocks when it sits in EX; further back its data is on a bus.
    assign hazard = bus.id_valid && sb[1].ld && (match_rs[1] || match_rt[1]);
    assign flush  = bus.mem_branch_taken;
    assign stall  = hazard && !flush;   // flush squashes the stalled instruction anyway
    assign issue  = bus.id_valid && !stall && !flush;

    // Scoreboard shift and forwarding select registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the scoreboard is reset (not left to fill with bubbles)
            // because stale valid bits would raise false stalls after reset.
            for (int k = 1; k <= DEPTH; k++) sb[k] <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every entry sample its
            // neighbour's pre-edge value, giving a true shift register.
            for (int k = DEPTH; k >= 2; k--) begin
                // Younger entries 1..FLUSH_DEPTH land in 2..FLUSH_DEPTH+1 as
                // bubbles; the branch itself (in MEM) keeps shifting.
                if (flush && (k <= FLUSH_DEPTH + 1)) sb[k] <= '0;
                else                                 sb[k] <= sb[k-1];
            end
            if (issue) begin
                sb[1]   <= '{v: 1'b1, wr: bus.id_regwrite, ld: bus.id_memread, rd: bus.id_rd};
                fwd_a_q <= sel_a;
                fwd_b_q <= sel_b;
            end else begin
                sb[1]   <= '0;
                fwd_a_q <= '0;
                fwd_b_q <= '0;
            end
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.stall     = stall;
    assign bus.flush     = flush;
    assign bus.fwd_a     = fwd_a_q;
    assign bus.fwd_b     = fwd_b_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
//   Directed vectors for hazard_fwd_unit. Each stimulus cycle pushes its
//   hand-computed expected outputs into a queue; a monitor on the falling
//   edge pops and compares. Counters use CNT_W = 4 so saturation is reachable.
module tb_hazard_fwd_unit;

    localparam int REG_AW = 5;
    localparam int DEPTH  = 3;
    localparam int CNT_W  = 4;
    localparam int SW     = $clog2(DEPTH + 1);
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    hazard_fwd_unit_if #(.REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    hazard_fwd_unit #(
        .REG_AW(REG_AW), .DEPTH(DEPTH), .FLUSH_DEPTH(1), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    stall;
        int    flush;
        int    fa;
        int    fb;
        int    sc;
        int    fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_sc  = 0;
    int   exp_fc  = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compares whatever the stimulus side expected for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, ".stall"},     int'(bus.stall),     mon_e.stall);
            check({mon_e.name, ".flush"},     int'(bus.flush),     mon_e.flush);
            check({mon_e.name, ".fwd_a"},     int'(bus.fwd_a),     mon_e.fa);
            check({mon_e.name, ".fwd_b"},     int'(bus.fwd_b),     mon_e.fb);
            check({mon_e.name, ".stall_cnt"}, int'(bus.stall_cnt), mon_e.sc);
            check({mon_e.name, ".flush_cnt"}, int'(bus.flush_cnt), mon_e.fc);
        end
    end

    task automatic drive(input bit v, input int rs, input int rt, input bit ut,
                         input bit rw, input int rd, input bit mr, input bit mbt);
        bus.id_valid         = v;
        bus.id_rs            = REG_AW'(rs);
        bus.id_rt            = REG_AW'(rt);
        bus.id_uses_rt       = ut;
        bus.id_regwrite      = rw;
        bus.id_rd            = REG_AW'(rd);
        bus.id_memread       = mr;
        bus.mem_branch_taken = mbt;
    endtask

    // One pipeline cycle: drive ID fields, queue expected outputs for this
    // cycle (fwd_* reflect the instruction issued in the previous cycle).
    task automatic step(input string name, input bit v, input int rs, input int rt,
                        input bit ut, input bit rw, input int rd, input bit mr,
                        input bit mbt, input int es, input int ef,
                        input int fa, input int fb);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v, rs, rt, ut, rw, rd, mr, mbt);
        e.name = name; e.stall = es; e.flush = ef; e.fa = fa; e.fb = fb;
        e.sc = exp_sc; e.fc = exp_fc;
        exp_q.push_back(e);
        if (es != 0 && exp_sc < CMAX) exp_sc++;
        if (ef != 0 && exp_fc < CMAX) exp_fc++;
    endtask

    task automatic idle(input string name, input int fa, input int fb);
        step(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb);
    endtask

    task automatic gap();
        for (int i = 0; i < 3; i++) idle("gap", 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_sc = 0;
        exp_fc = 0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("reset.stall",     int'(bus.stall),     0);
        check("reset.flush",     int'(bus.flush),     0);
        check("reset.fwd_a",     int'(bus.fwd_a),     0);
        check("reset.fwd_b",     int'(bus.fwd_b),     0);
        check("reset.stall_cnt", int'(bus.stall_cnt), 0);
        check("reset.flush_cnt", int'(bus.flush_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // EX/MEM forwarding: add $3<-$1,$2 ; sub $4<-$3,$5
        step("fwd_add", 1, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        step("fwd_sub", 1, 3, 5, 1, 1, 4, 0, 0, 0, 0, 0, 0);
        idle("fwd_ex", 1, 0);
        gap();

        // Load-use: lw $8 ; add $10<-$9,$8 stalls once, then issues with fwd_b=2
        step("lu_lw",    1, 1, 0, 0, 1, 8,  1, 0, 0, 0, 0, 0);
        step("lu_stall", 1, 9, 8, 1, 1, 10, 0, 0, 1, 0, 0, 0);
        step("lu_issue", 1, 9, 8, 1, 1, 10, 0, 0, 0, 0, 0, 0);
        idle("lu_ex", 0, 2);
        gap();

        // Nearest producer: three writes to $6, then read $6
        step("near_w1",   1, 1, 2, 1, 1, 6, 0, 0, 0, 0, 0, 0);
        step("near_w2",   1, 1, 2, 1, 1, 6, 0, 0, 0, 0, 0, 0);
        step("near_w3",   1, 1, 2, 1, 1, 6, 0, 0, 0, 0, 0, 0);
        step("near_read", 1, 6, 2, 1, 1, 7, 0, 0, 0, 0, 0, 0);
        idle("near_ex", 1, 0);
        gap();

        // Register zero: lw $0 ; add $11<-$0,$0 -> no stall, no forwarding
        step("zero_lw",  1, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0);
        step("zero_add", 1, 0, 0, 1, 1, 11, 0, 0, 0, 0, 0, 0);
        idle("zero_ex", 0, 0);
        gap();

        // Load-use and taken branch together: flush wins, lw is killed
        do_reset();
        step("sim_lw",    1, 1,  0, 0, 1, 12, 1, 0, 0, 0, 0, 0);
        step("sim_both",  1, 12, 1, 1, 1, 13, 0, 1, 0, 1, 0, 0);
        step("sim_probe", 1, 12, 1, 1, 1, 13, 0, 0, 0, 0, 0, 0);
        idle("sim_ex", 0, 0);
        gap();

        // Counter saturation: 20 load-use stalls with a 4-bit counter
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step("sat_lw",    1, 1, 0, 0, 1, 8,  1, 0, 0, 0, 0, (i == 0) ? 0 : 2);
            step("sat_stall", 1, 9, 8, 1, 1, 10, 0, 0, 1, 0, 0, 0);
            step("sat_issue", 1, 9, 8, 1, 1, 10, 0, 0, 0, 0, 0, 0);
        end
        idle("sat_end", 0, 2);

        // Asynchronous reset in the middle of a stall with fwd_a = 1 showing
        step("ar_add", 1, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        step("ar_lw",  1, 3, 0, 0, 1, 8, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 9, 8, 1, 1, 10, 0, 0);
        #1;
        check("ar_pre.stall",     int'(bus.stall),     1);
        check("ar_pre.fwd_a",     int'(bus.fwd_a),     1);
        check("ar_pre.stall_cnt", int'(bus.stall_cnt), CMAX);
        rst = 1'b1;
        #1;
        check("ar_post.stall",     int'(bus.stall),     0);
        check("ar_post.fwd_a",     int'(bus.fwd_a),     0);
        check("ar_post.fwd_b",     int'(bus.fwd_b),     0);
        check("ar_post.stall_cnt", int'(bus.stall_cnt), 0);
        check("ar_post.flush_cnt", int'(bus.flush_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_sc = 0;
        exp_fc = 0;
        // Same add after reset: scoreboard is empty, so it issues without a stall
        step("ar_after", 1, 9, 8, 1, 1, 10, 0, 0, 0, 0, 0, 0);
        idle("ar_idle", 0, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard-control block for the five-stage MIPS pipeline: tracks in-flight destination registers in a DEPTH-entry scoreboard shift register and generates forwarding selects, load-use stalls and branch flushes. It sits beside I_Decode, consumes ID-stage operand fields and the MEM-stage branch decision, and drives the PC/IF-ID write enables and the EX operand muxes. It replaces the hazard-free behaviour of the current pipeline and generalises forwarding to any number of result buses.

## Interface
Parameters:
- REG_AW, 5, register address width
- DEPTH, 3, scoreboard entries; entry 1 = EX, 2 = MEM, 3 = WB
- FLUSH_DEPTH, 1, younger scoreboard entries killed on a taken branch, in addition to ID; legal 0..DEPTH-1
- CNT_W, 16, width of the statistics counters
- SW, clog2(DEPTH+1), forwarding select width (derived)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_AW  source A
- id_rt  in  REG_AW  source B
- id_uses_rt  in  1  rt is read as an operand; not set for I-type ALU ops or loads
- id_regwrite  in  1  ID instruction writes a register
- id_rd  in  REG_AW  destination after the regdst mux
- id_memread  in  1  ID instruction is a load
- mem_branch_taken  in  1  taken branch resolved in MEM (MEM_PCSrc)
- stall  out  1  combinational: hold PC and IF/ID, insert bubble into ID/EX
- flush  out  1  combinational: squash IF/ID and ID/EX
- fwd_a  out  SW  registered EX operand-A select: 0 = register file, k = result bus k (1 = EX/MEM, 2 = MEM/WB, ...)
- fwd_b  out  SW  registered EX operand-B select, same encoding
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flush events

## Operation
- Entry k holds {v, wr, ld, rd}. An entry is a producer when v & wr & rd != 0; register 0 never matches.
- Match: ID source s matches entry k when entry k is a producer and its rd equals s. rt is checked only if id_uses_rt.
- Hazard: the ID instruction is valid and entry 1 has ld = 1 and matches rs or rt. Hazard sets stall = hazard & !mem_branch_taken.
- flush = mem_branch_taken.
- Forwarding: for each source, the select is the lowest k whose entry matches, else 0. The nearest producer wins.
- Shift every cycle (no enable):
  - entry[k+1] <= entry[k]
  - entry[1] <= ID instruction if id_valid & !stall & !flush, else a bubble with v = 0
- Flush kill: on flush, entries 1..FLUSH_DEPTH are written as bubbles at their shifted positions 2..FLUSH_DEPTH+1. The branch in MEM is not killed.
- fwd_a / fwd_b are registered with the entry[1] update. When a bubble enters, they load 0.
- Load at a tracked distance ≥ 2 is forwarded normally because its data is on bus k ≥ 2.
- Counters:
  - stall_cnt increments on each cycle with stall = 1
  - flush_cnt increments on each cycle with flush = 1
  - both hold at 2^CNT_W − 1

## Timing
- Reset value: all entries v = 0; fwd_a = fwd_b = 0; both counters 0; stall = flush = 0 while no inputs are asserted.
- stall and flush are valid in the same cycle as the causing inputs, with zero latency.
- fwd_a and fwd_b have 1-cycle latency. They are valid in the cycle the instruction occupies EX.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in entry 2, and the held instruction issues with select 2.
- Back-to-back loads, each consumed immediately: each pair produces one stall.
- Stall and flush in the same cycle: flush wins, stall = 0, stall_cnt does not increment.
- Reset asserted mid-stall: the scoreboard clears immediately (asynchronous) and stall drops in the same cycle.

## Test plan
- **Forwarding from EX/MEM:** add $3←$1,$2, then sub $4←$3,$5 -> fwd_a = 1 and fwd_b = 0 while the sub is in EX; no stall.
- **Load-use:** lw $8, then add using $8 as rt -> stall = 1 for exactly one cycle; next cycle fwd_b = 2; stall_cnt = 1.
- **Nearest producer wins:** three consecutive writes to $6, then a read of $6 -> fwd_a = 1, not 2 or 3.
- **Register zero:** write to $0, then a read of $0 -> fwd_a = 0 and no stall even if the writer is a load.
- **Simultaneous events:** load-use hazard and mem_branch_taken in the same cycle -> flush = 1, stall = 0; the next-cycle entries 1 and 2 are bubbles; flush_cnt = 1, stall_cnt = 0.
- **Counter saturation:** with CNT_W = 4, force 20 stall cycles -> stall_cnt stops at 15. Asynchronous rst mid-run -> counters, fwd_a and fwd_b all 0 immediately.
